rf_dump_reader: RTL and testbench

- Debug read-out engine for the CPU register file.
- On a start pulse it walks an inclusive address range on one register-file read port.
- It captures each word and streams it out over a valid/ready handshake, tagged with its address.
- It keeps a running XOR checksum of the words sent, so a bench or debug host can snapshot architectural state without stalling the testbench.

---
 rtl/rf_dump_reader.sv | 149 ++++++++++++++
 tb/tb_rf_dump_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// rf_dump_reader
//   Debug read-out engine for the CPU register file. A start pulse walks an
//   inclusive address range on one register-file read port. Each word is
//   captured and streamed out over a valid/ready handshake, tagged with its
//   address. A running XOR checksum of the transferred words is kept.
//
// Ports
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   start, abort     begin a dump (sampled in IDLE) / cancel a dump in progress
//   first_addr,
//   last_addr        inclusive range, sampled with start; wraps at NUM_REGS-1
//   rf_addr, rf_data register-file read port (combinational read data)
//   out_valid/ready  output handshake
//   out_data/addr    captured word and its address
//   out_last         current word is the final word of the range
//   busy, done       busy in FETCH/PRESENT; one-cycle done after the last word
//   checksum         XOR of words transferred in the current/most recent dump
module rf_dump_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   rf_addr_q,   rf_addr_d;
  logic [ADDR_W-1:0]   last_q,      last_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic                out_last_q,  out_last_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   checksum_q,  checksum_d;

  // The first address needs no separate latch: rf_addr is loaded with it at
  // start and then advances from there.
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    checksum_d  = checksum_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d     = last_addr;
          rf_addr_d  = first_addr;
          checksum_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_data_d  = rf_data;
          out_addr_d  = rf_addr_q;
          out_last_d  = (rf_addr_q == last_q);
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // abort takes priority over a same-cycle handshake
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          checksum_d  = checksum_q ^ out_data_q;
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            rf_addr_d = (rf_addr_q == ADDR_W'(NUM_REGS - 1)) ? '0
                                                              : rf_addr_q + 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rf_addr_q   <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      checksum_q  <= checksum_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign checksum  = checksum_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_PRESENT);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader
//   Directed bench for rf_dump_reader with a behavioural register file
//   R[i] = i * 0x01010101 (so R0 = 0) feeding rf_data combinationally.
module tb_rf_dump_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign rf_data = regs[rf_addr];

  rf_dump_reader #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one dump from f to l and checks every word, done timing and checksum.
  // backp: hold out_ready low for two cycles of each word before accepting.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit backp);
    logic [4:0]  exp_addr;
    logic [4:0]  span;
    logic [31:0] x;
    logic [31:0] cap;
    int          cyc;
    int          nw;
    int          w;
    int          n_exp;
    bit          got_done;
    bit          seen_first;
    span       = l - f;
    n_exp      = int'(span) + 1;
    exp_addr   = f;
    x          = '0;
    cap        = '0;
    nw         = 0;
    w          = 0;
    got_done   = 1'b0;
    seen_first = 1'b0;
    out_ready  = 1'b1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    cyc        = 1;
    for (int g = 0; g < 400; g++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (out_valid) begin
        if (w == 0) begin
          if (!seen_first) begin
            chk("first_valid_latency", 32'(cyc), 32'd2);
            seen_first = 1'b1;
          end
          chk("out_addr", 32'(out_addr), 32'(exp_addr));
          chk("out_data", out_data, regs[exp_addr]);
          chk("out_last", 32'(out_last), 32'(exp_addr == l));
          cap = out_data;
        end else begin
          chk("hold_data", out_data, cap);
          chk("hold_addr", 32'(out_addr), 32'(exp_addr));
        end
        out_ready = !backp || (w >= 2);
        if (out_ready) begin
          x        = x ^ regs[exp_addr];
          nw++;
          exp_addr = exp_addr + 5'd1;
          w        = 0;
        end else begin
          w++;
        end
      end
      tick();
      cyc++;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("word_count", 32'(nw), 32'(n_exp));
    chk("checksum", checksum, x);
    chk("busy_in_done", 32'(busy), 32'd0);
    if (!backp) chk("done_cycle", 32'(cyc), 32'(2 * n_exp + 1));
    out_ready = 1'b1;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    chk("checksum_held", checksum, x);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
    RST        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    // full dump 0..31 (XOR of i*0x01010101 for i=0..31 is 0)
    run_dump(5'd0, 5'd31, 1'b0);
    // backpressure
    run_dump(5'd5, 5'd7, 1'b1);
    // wrap 30,31,0,1 then single word
    run_dump(5'd30, 5'd1, 1'b0);
    chk("wrap_checksum", checksum, 32'h1E1E1E1E ^ 32'h1F1F1F1F ^ 32'h01010101);
    run_dump(5'd12, 5'd12, 1'b0);
    chk("single_checksum", checksum, 32'h0C0C0C0C);

    // ignored start during PRESENT of word 3, then abort in PRESENT of word 4
    out_ready  = 1'b1;
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("ab_word3_valid", 32'(out_valid), 32'd1);
    chk("ab_word3_addr", 32'(out_addr), 32'd3);
    first_addr = 5'd10;
    last_addr  = 5'd10;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_start_ignored_busy", 32'(busy), 32'd1);
    tick();
    chk("ab_word4_addr", 32'(out_addr), 32'd4);
    chk("ab_word4_valid", 32'(out_valid), 32'd1);
    chk("ab_partial_checksum", checksum, 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_busy", 32'(busy), 32'd0);
    chk("ab_out_valid", 32'(out_valid), 32'd0);
    chk("ab_out_last", 32'(out_last), 32'd0);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_checksum", checksum, 32'h0);
    tick();
    chk("ab_no_done_later", 32'(done), 32'd0);
    chk("ab_checksum_later", checksum, 32'h0);

    // abort with a nonzero partial checksum: 5 accepted, abort in PRESENT of 6
    first_addr = 5'd5;
    last_addr  = 5'd9;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    chk("ab2_word6_addr", 32'(out_addr), 32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab2_checksum", checksum, 32'h05050505);
    chk("ab2_out_valid", 32'(out_valid), 32'd0);

    // async reset between edges while in FETCH
    first_addr = 5'd5;
    last_addr  = 5'd20;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_rf_addr", 32'(rf_addr), 32'd6);
    chk("pre_rst_checksum", checksum, 32'h05050505);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_addr", 32'(out_addr), 32'd0);
    chk("arst_rf_addr", 32'(rf_addr), 32'd0);
    chk("arst_checksum", checksum, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #2;
    RST = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    run_dump(5'd3, 5'd3, 1'b0);
    chk("post_rst_checksum", checksum, 32'h03030303);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
